// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl_if
//  Description : Request/response bundle between the memory stage (master)
//                and the data memory controller (slave).
//  Revision    : 1.0
// ============================================================================
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              Req;
    logic              Ready;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataWr;
    logic              DMWr;
    logic [2:0]        DMCtrl;
    logic              Valid;
    logic [31:0]       DataRd;
    logic              Err;

    modport master (
        output Req, Address, DataWr, DMWr, DMCtrl,
        input  Ready, Valid, DataRd, Err
    );

    modport slave (
        input  Req, Address, DataWr, DMWr, DMCtrl,
        output Ready, Valid, DataRd, Err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Byte-lane data memory with request/ready handshake, fixed
//                access latency and RISC-V load/store width decode.
//                Optional macro DM_MISALIGN_SPLIT_EN makes misaligned accesses
//                legal, splitting word-crossing ones over two words.
//  Revision    : 1.0
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int RD_LATENCY  = 1
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int         IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_RELOAD = 3'(RD_LATENCY);

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SPLIT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             err_q, err_d;
    logic             split_q, split_d;
    logic             valid_q, valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [31:0]      mem_q [DEPTH_WORDS];

    // ---------------- request decode (evaluated on the accept edge) --------
    logic             w_illegal, w_oor, w_oor_any, w_misalign_err, w_split_in, w_err_in;
    logic             w_is_half, w_is_word;
    logic [IDX_W-1:0] w_idx_in;

    assign w_idx_in  = bus.Address[IDX_W+1:2];
    assign w_is_half = (bus.DMCtrl == DM_H) || (bus.DMCtrl == DM_HU);
    assign w_is_word = (bus.DMCtrl == DM_W);

    always_comb begin
        w_illegal = 1'b0;
        case (bus.DMCtrl)
            DM_B, DM_H, DM_W: w_illegal = 1'b0;
            DM_BU, DM_HU:     w_illegal = bus.DMWr;
            default:          w_illegal = 1'b1;
        endcase
    end

    generate
        if (ADDR_W > IDX_W + 2) begin : g_range_hi
            assign w_oor = |bus.Address[ADDR_W-1:IDX_W+2];
        end else begin : g_range_none
            assign w_oor = 1'b0;
        end
    endgenerate

`ifdef DM_MISALIGN_SPLIT_EN
    logic w_cross;
    logic w_last;
    assign w_cross        = (w_is_half && (bus.Address[1:0] == 2'b11)) ||
                            (w_is_word && (bus.Address[1:0] != 2'b00));
    assign w_last         = &w_idx_in;
    // The second word must also exist, otherwise neither word is touched.
    assign w_oor_any      = w_oor || (w_cross && w_last);
    assign w_misalign_err = 1'b0;
    assign w_split_in     = w_cross;
`else
    assign w_oor_any      = w_oor;
    assign w_misalign_err = (w_is_half && bus.Address[0]) ||
                            (w_is_word && (bus.Address[1:0] != 2'b00));
    assign w_split_in     = 1'b0;
`endif

    assign w_err_in = w_illegal || w_oor_any || w_misalign_err;

    // ---------------- datapath over the {word+1, word} pair ----------------
    logic [IDX_W-1:0] w_idx_hi;
    logic [63:0]      w_pair;
    logic [31:0]      w_slice;
    logic [3:0]       w_base_mask;
    logic [7:0]       w_mask;
    logic [63:0]      w_wdata;
    logic [31:0]      w_load;

    assign w_idx_hi = idx_q + 1'b1;
    assign w_pair   = {mem_q[w_idx_hi], mem_q[idx_q]};
    assign w_slice  = w_pair[{off_q, 3'b000} +: 32];
    assign w_mask   = {4'b0000, w_base_mask} << off_q;
    assign w_wdata  = {32'd0, wdata_q} << {off_q, 3'b000};

    always_comb begin
        w_base_mask = 4'b0000;
        w_load      = 32'd0;
        case (ctrl_q)
            DM_B:  begin w_base_mask = 4'b0001; w_load = {{24{w_slice[7]}}, w_slice[7:0]};   end
            DM_BU: begin w_base_mask = 4'b0001; w_load = {24'd0, w_slice[7:0]};              end
            DM_H:  begin w_base_mask = 4'b0011; w_load = {{16{w_slice[15]}}, w_slice[15:0]}; end
            DM_HU: begin w_base_mask = 4'b0011; w_load = {16'd0, w_slice[15:0]};             end
            DM_W:  begin w_base_mask = 4'b1111; w_load = w_slice;                            end
            default: ;
        endcase
    end

    // ---------------- control FSM ------------------------------------------
    logic w_finish;
    logic w_commit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        ctrl_d    = ctrl_q;
        err_d     = err_q;
        split_d   = split_q;
        valid_d   = 1'b0;
        rsp_err_d = 1'b0;
        rdata_d   = 32'd0;
        w_finish  = 1'b0;
        w_commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Req) begin
                    idx_d   = w_idx_in;
                    off_d   = bus.Address[1:0];
                    wdata_d = bus.DataWr;
                    wr_d    = bus.DMWr;
                    ctrl_d  = bus.DMCtrl;
                    err_d   = w_err_in;
                    split_d = w_split_in && !w_err_in;
                    cnt_d   = CNT_RELOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (split_q) begin
                        cnt_d   = CNT_RELOAD;
                        state_d = S_SPLIT;
                    end else begin
                        w_finish = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_SPLIT: begin
                if (cnt_q == 3'd0) begin
                    w_finish = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (w_finish) begin
            state_d   = S_RESP;
            valid_d   = 1'b1;
            rsp_err_d = err_q;
            rdata_d   = (err_q || wr_q) ? 32'd0 : w_load;
            w_commit  = wr_q && !err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            idx_q     <= '0;
            off_q     <= 2'd0;
            wdata_q   <= 32'd0;
            wr_q      <= 1'b0;
            ctrl_q    <= 3'd0;
            err_q     <= 1'b0;
            split_q   <= 1'b0;
            valid_q   <= 1'b0;
            rsp_err_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            ctrl_q    <= ctrl_d;
            err_q     <= err_d;
            split_q   <= split_d;
            valid_q   <= valid_d;
            rsp_err_q <= rsp_err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage is never reset; a reset forces IDLE, which blocks any commit.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b])     mem_q[idx_q][8*b +: 8]    <= w_wdata[8*b +: 8];
                if (w_mask[b + 4]) mem_q[w_idx_hi][8*b +: 8] <= w_wdata[32 + 8*b +: 8];
            end
        end
    end

    assign bus.Ready  = (state_q == S_IDLE);
    assign bus.Valid  = valid_q;
    assign bus.Err    = rsp_err_q;
    assign bus.DataRd = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Randomised self-checking bench for data_mem_ctrl against a
//                byte-addressed reference model.
//  Revision    : 1.0
// ============================================================================
module tb_data_mem_ctrl;
    localparam int DEPTH = 64;
    localparam int LAT   = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b1;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] mem_m [DEPTH*4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_ctrl_if #(.ADDR_W(32)) bus ();

    data_mem_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (32),
        .RD_LATENCY  (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Reference: byte-addressed memory, sizes and alignment from the ISA rules.
    function automatic void model(input bit wr, input logic [2:0] ctrl, input logic [31:0] addr,
                                  input logic [31:0] data, output bit err,
                                  output logic [31:0] rd, output bit split);
        longint unsigned a;
        int  size;
        bit  sgn, legal;
        a = {32'd0, addr};
        size = 1; sgn = 1'b0; legal = 1'b1;
        case (ctrl)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: size = 4;
            3'b100: size = 1;
            3'b101: size = 2;
            default: legal = 1'b0;
        endcase
        if (wr && (ctrl == 3'b100 || ctrl == 3'b101)) legal = 1'b0;
        err   = !legal || (a / 4 >= DEPTH);
        split = 1'b0;
        if (legal && (a % size != 0)) begin
`ifdef DM_MISALIGN_SPLIT_EN
            if ((a % 4) + size > 4) begin
                split = 1'b1;
                if ((a + size - 1) / 4 >= DEPTH) err = 1'b1;
            end
`else
            err = 1'b1;
`endif
        end
        if (err) split = 1'b0;
        rd = 32'd0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < size; i++) mem_m[int'(a) + i] = data[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) rd[8*i +: 8] = mem_m[int'(a) + i];
                if (sgn) for (int j = 8*size; j < 32; j++) rd[j] = rd[8*size-1];
            end
        end
    endfunction

    task automatic scramble();
        bus.Address = $urandom;
        bus.DataWr  = $urandom;
        bus.DMWr    = 1'($urandom);
        bus.DMCtrl  = 3'($urandom);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (bus.Ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                chk("ready_timeout", 32'(bus.Ready), 32'd1);
                finish_run();
            end
        end
    endtask

    // Called at a negedge; Req is raised at once, possibly while still busy.
    task automatic issue(input bit wr, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] data, input bit lit,
                         input logic [31:0] ld, input bit le);
        bit          me, sp;
        logic [31:0] md;
        exp_t        x;
        bus.Req = 1'b1; bus.DMWr = wr; bus.DMCtrl = ctrl; bus.Address = addr; bus.DataWr = data;
        wait_ready();
        @(posedge clk); #1;
        model(wr, ctrl, addr, data, me, md, sp);
        x.cyc = cyc + LAT + 1 + (sp ? LAT + 1 : 0);
        x.d   = lit ? ld : md;
        x.e   = lit ? le : me;
        exp_q.push_back(x);
        bus.Req = 1'b0;
        scramble();
        @(negedge clk);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk); #1;
            guard++;
            if (guard > 30) begin
                chk("drain_timeout", 32'(exp_q.size()), 32'd0);
                finish_run();
            end
        end
    endtask

    always @(negedge clk) begin
        bit ev;
        if (rst_n && cmp_en) begin
            ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("ready", 32'(bus.Ready), 32'(exp_q.size() == 0));
            chk("valid", 32'(bus.Valid), 32'(ev));
            if (ev) begin
                chk("rdata", bus.DataRd, exp_q[0].d);
                chk("err", 32'(bus.Err), 32'(exp_q[0].e));
                void'(exp_q.pop_front());
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        chk("watchdog", 32'd1, 32'd0);
        finish_run();
    end

    initial begin
        bus.Req = 1'b0;
        scramble();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.Ready), 32'd1);
        chk("rst_valid", 32'(bus.Valid), 32'd0);
        chk("rst_err", 32'(bus.Err), 32'd0);
        chk("rst_rdata", bus.DataRd, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < DEPTH; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0, 32'd0, 1'b0);

        // T1 / T2 / T3
        issue(1'b1, 3'b010, 32'd0,  32'h5555_5555, 1'b1, 32'h0000_0000, 1'b0);
        issue(1'b0, 3'b010, 32'd0,  32'h0,         1'b1, 32'h5555_5555, 1'b0);
        issue(1'b1, 3'b010, 32'd8,  32'h1234_5678, 1'b1, 32'h0000_0000, 1'b0);
        issue(1'b1, 3'b000, 32'd9,  32'h0000_00AB, 1'b1, 32'h0000_0000, 1'b0);
        issue(1'b0, 3'b000, 32'd9,  32'h0,         1'b1, 32'hFFFF_FFAB, 1'b0);
        issue(1'b0, 3'b100, 32'd9,  32'h0,         1'b1, 32'h0000_00AB, 1'b0);
        issue(1'b0, 3'b010, 32'd8,  32'h0,         1'b1, 32'h1234_AB78, 1'b0);
        issue(1'b1, 3'b001, 32'd14, 32'h0000_8001, 1'b1, 32'h0000_0000, 1'b0);
        issue(1'b0, 3'b001, 32'd14, 32'h0,         1'b1, 32'hFFFF_8001, 1'b0);
        issue(1'b0, 3'b101, 32'd14, 32'h0,         1'b1, 32'h0000_8001, 1'b0);
        // T5
        issue(1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 1'b1, 32'h0000_0000, 1'b1);
        issue(1'b0, 3'b011, 32'd0,  32'h0,         1'b1, 32'h0000_0000, 1'b1);
        issue(1'b1, 3'b100, 32'd0,  32'h0000_0011, 1'b1, 32'h0000_0000, 1'b1);
        issue(1'b0, 3'b010, 32'd0,  32'h0,         1'b1, 32'h5555_5555, 1'b0);
        // T4
`ifdef DM_MISALIGN_SPLIT_EN
        issue(1'b1, 3'b010, 32'd2,  32'hCAFE_F00D, 1'b1, 32'h0000_0000, 1'b0);
        issue(1'b0, 3'b010, 32'd0,  32'h0,         1'b1, 32'hF00D_5555, 1'b0);
        issue(1'b0, 3'b101, 32'd4,  32'h0,         1'b1, 32'h0000_CAFE, 1'b0);
        issue(1'b0, 3'b010, 32'(DEPTH * 4 - 2), 32'h0, 1'b1, 32'h0000_0000, 1'b1);
`else
        issue(1'b0, 3'b010, 32'd2,  32'h0,         1'b1, 32'h0000_0000, 1'b1);
        issue(1'b1, 3'b010, 32'd3,  32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b1);
        issue(1'b0, 3'b001, 32'd1,  32'h0,         1'b1, 32'h0000_0000, 1'b1);
        issue(1'b0, 3'b010, 32'd0,  32'h0,         1'b1, 32'h5555_5555, 1'b0);
`endif

        // T6: reset during WAIT of a store drops it completely
        drain();
        cmp_en = 1'b0;
        bus.Req = 1'b1; bus.DMWr = 1'b1; bus.DMCtrl = 3'b010;
        bus.Address = 32'd16; bus.DataWr = 32'hFFFF_FFFF;
        wait_ready();
        @(posedge clk); #1;
        bus.Req = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(bus.Ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 32'(bus.Ready), 32'd1);
        chk("t6_valid", 32'(bus.Valid), 32'd0);
        chk("t6_err", 32'(bus.Err), 32'd0);
        chk("t6_rdata", bus.DataRd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        cmp_en = 1'b1;
        @(negedge clk);
        issue(1'b0, 3'b010, 32'd16, 32'h0, 1'b0, 32'h0, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 70)      a = $urandom_range(0, DEPTH * 4 - 1);
            else if (sel < 85) a = 32'(DEPTH * 4 - 4 + $urandom_range(0, 7));
            else               a = $urandom;
            issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, 1'b0, 32'h0, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        drain();
        repeat (2) @(negedge clk);
        finish_run();
    end
endmodule
`default_nettype wire
